packetfilt_dispatcher: RTL and testbench
========================================

# packetfilt_dispatcher

Order-preserving dispatcher between one AXI-Stream snooper, one forwarder and N parallel BPF VM packet memories. Incoming packets are assigned round-robin to free VMs. The VM index of each accepted snoop is queued, and the forwarder is granted to VMs strictly in snoop order. Rejected packets are retired without forwarding.

## Interface
Parameters:
- `N`, 8: number of VMs; power of two, 2..16. Localparam `IW = $clog2(N)`.
- `SNOOP_FWD_ADDR_WIDTH`, 8: packet memory word address width `A`.
- `DATA_WIDTH`, 128: packet memory word width `D`.

Ports:
- `axi_aclk`  in  1  clock
- `axi_aresetn`  in  1  asynchronous active-low reset
- `snooper_wr_addr`  in  A  snooper write address
- `snooper_wr_data`  in  D  snooper write data
- `snooper_wr_en`  in  1  snooper write enable
- `snooper_done`  in  1  end-of-packet, 1-cycle pulse
- `ready_for_snooper`  out  1  a VM is allocated to the snooper
- `vm_snooper_wr_addr`  out  A  broadcast of `snooper_wr_addr`
- `vm_snooper_wr_data`  out  D  broadcast of `snooper_wr_data`
- `vm_snooper_wr_en`  out  N  one-hot write enable
- `vm_snooper_done`  out  N  one-hot done pulse
- `vm_ready_for_snooper`  in  N  VM packet memory is free
- `vm_rej`  in  N  VM rejected its packet, 1-cycle pulse
- `forwarder_rd_addr`  in  A  forwarder read address
- `forwarder_rd_en`  in  1  forwarder read enable
- `forwarder_rd_data`  out  D  read data muxed from the granted VM
- `forwarder_done`  in  1  forward complete, 1-cycle pulse
- `ready_for_forwarder`  out  1  a granted VM holds an accepted packet
- `len_to_forwarder`  out  A+1  latched length of the granted packet
- `vm_forwarder_rd_addr`  out  A  broadcast of `forwarder_rd_addr`
- `vm_forwarder_rd_en`  out  N  one-hot read enable
- `vm_forwarder_rd_data`  in  N*D  VM i occupies bits [i*D +: D]
- `vm_forwarder_done`  out  N  one-hot done pulse
- `vm_ready_for_forwarder`  in  N  VM accepted its packet
- `vm_len_to_forwarder`  in  N*(A+1)  per-VM packet length
- `outstanding`  out  IW+1  number of queued (snooped, not retired) packets

## Operation
- State per VM: `busy[i]` and `rej_flag[i]`. Order queue: FIFO of depth N, entry width IW. Each VM appears in the queue at most once, so the FIFO can never overflow.
- Snoop FSM, states S_IDLE and S_ACTIVE, register `ssel`, round-robin pointer `last_s`:
  - S_IDLE: scan upward from `last_s+1` mod N for the first `i` with `vm_ready_for_snooper[i] && !busy[i]`. If found: `ssel<=i`, `last_s<=i`, go to S_ACTIVE.
  - S_ACTIVE: `ready_for_snooper=1`; `vm_snooper_wr_en[ssel]=snooper_wr_en`.
  - In S_ACTIVE, on `snooper_done`: pulse `vm_snooper_done[ssel]`, push `ssel`, set `busy[ssel]`, go to S_IDLE.
  - Writes arriving in S_IDLE are dropped; all `vm_snooper_wr_en` stay 0.
- Reject tracking: `vm_rej[i]` with `busy[i]=1` sets `rej_flag[i]`. `vm_rej[i]` with `busy[i]=0` is ignored.
- Forward FSM, states F_IDLE and F_ACTIVE; `h` is the FIFO head:
  - F_IDLE, queue non-empty, `rej_flag[h]=1`: pop; clear `busy[h]` and `rej_flag[h]`; stay in F_IDLE.
  - F_IDLE, queue non-empty, `rej_flag[h]=0`, `vm_ready_for_forwarder[h]=1`: latch `fsel<=h` and `len_to_forwarder<=vm_len_to_forwarder[h]`; go to F_ACTIVE.
  - F_ACTIVE: `ready_for_forwarder=1`; `vm_forwarder_rd_en[fsel]=forwarder_rd_en`; `forwarder_rd_data` is a combinational mux of VM `fsel`, so the VM's own read latency passes through unchanged.
  - In F_ACTIVE, on `forwarder_done`: pulse `vm_forwarder_done[fsel]`, pop, clear `busy[fsel]`, go to F_IDLE.
- A simultaneous push and pop leaves the count unchanged. `outstanding` equals the FIFO count.

## Timing
- Reset (async, while `axi_aresetn=0`):
  - All outputs 0.
  - FIFO empty; `busy` and `rej_flag` cleared.
  - `last_s=N-1`, so VM0 is picked first.
  - Reset mid-packet discards all state; no done pulses are emitted.
- `ready_for_snooper`, `ready_for_forwarder` and `len_to_forwarder` are registered.
- Done pulses and the one-hot enables are combinational from registered select plus the input; zero latency.
- Snoop side:
  - VM becomes free (idle) -> `ready_for_snooper` high 1 cycle later.
  - `snooper_done` -> `ready_for_snooper` low for at least 1 cycle before the next allocation.
- Forward side:
  - Head ready -> `ready_for_forwarder` high 1 cycle later.
  - A rejected head costs 1 cycle to retire.
  - `forwarder_done` -> at least 1 idle cycle before the next grant.
- A `vm_rej` to the current head is seen one cycle later because the flag is registered.
- A `vm_rej` for `fsel` during F_ACTIVE is ignored, since the VM already accepted.

## Test plan
- Reset, all VMs ready, three 4-word packets -> snooped to VM0, VM1, VM2 in that order; `outstanding` reads 1, 2, 3.
- VM0 and VM1 both accept, VM1 becomes ready 20 cycles before VM0 -> VM0 is still forwarded first; `len_to_forwarder` equals VM0's length (e.g. 60).
- VM1 pulses `vm_rej` while VM0 is forwarding -> after VM0's `forwarder_done`, VM1 is popped in 1 cycle with no `ready_for_forwarder`; VM2 is granted next.
- All 8 VMs busy -> `ready_for_snooper` stays 0 and snoop writes are dropped; the first retirement re-enables the snooper on the VM after `last_s` that is free.
- Push and pop in the same cycle at `outstanding=3` -> `outstanding` stays 3.
- Drop `axi_aresetn` mid-snoop and mid-forward -> all outputs 0 immediately; after release, the next allocation goes to VM0.

Source files
------------

// File: rtl/packetfilt_dispatcher.sv
// Order-preserving dispatcher: snooper packets go round-robin to free BPF VMs,
// and the forwarder is granted to VMs strictly in the order they were snooped.
module packetfilt_dispatcher #(
  parameter int N                    = 8,
  parameter int SNOOP_FWD_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH           = 128
) (
  input  logic                                  axi_aclk,
  input  logic                                  axi_aresetn,

  input  logic [SNOOP_FWD_ADDR_WIDTH-1:0]       snooper_wr_addr,
  input  logic [DATA_WIDTH-1:0]                 snooper_wr_data,
  input  logic                                  snooper_wr_en,
  input  logic                                  snooper_done,
  output logic                                  ready_for_snooper,

  output logic [SNOOP_FWD_ADDR_WIDTH-1:0]       vm_snooper_wr_addr,
  output logic [DATA_WIDTH-1:0]                 vm_snooper_wr_data,
  output logic [N-1:0]                          vm_snooper_wr_en,
  output logic [N-1:0]                          vm_snooper_done,
  input  logic [N-1:0]                          vm_ready_for_snooper,
  input  logic [N-1:0]                          vm_rej,

  input  logic [SNOOP_FWD_ADDR_WIDTH-1:0]       forwarder_rd_addr,
  input  logic                                  forwarder_rd_en,
  output logic [DATA_WIDTH-1:0]                 forwarder_rd_data,
  input  logic                                  forwarder_done,
  output logic                                  ready_for_forwarder,
  output logic [SNOOP_FWD_ADDR_WIDTH:0]         len_to_forwarder,

  output logic [SNOOP_FWD_ADDR_WIDTH-1:0]       vm_forwarder_rd_addr,
  output logic [N-1:0]                          vm_forwarder_rd_en,
  input  logic [N*DATA_WIDTH-1:0]               vm_forwarder_rd_data,
  output logic [N-1:0]                          vm_forwarder_done,
  input  logic [N-1:0]                          vm_ready_for_forwarder,
  input  logic [N*(SNOOP_FWD_ADDR_WIDTH+1)-1:0] vm_len_to_forwarder,

  output logic [$clog2(N):0]                    outstanding
);

  localparam int A  = SNOOP_FWD_ADDR_WIDTH;
  localparam int D  = DATA_WIDTH;
  localparam int IW = $clog2(N);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;
  localparam logic [0:0] F_IDLE   = 1'b0;
  localparam logic [0:0] F_ACTIVE = 1'b1;

  localparam logic [IW-1:0] PTR_ONE = IW'(1);
  localparam logic [IW:0]   CNT_ONE = (IW+1)'(1);

  logic [0:0]    s_state, f_state;
  logic [IW-1:0] ssel, last_s, fsel;
  logic [N-1:0]  busy, rej_flag;
  logic [IW-1:0] fifo_mem [N];
  logic [IW-1:0] rd_ptr, wr_ptr;
  logic [IW:0]   count;
  logic [A:0]    len_q;

  logic          scan_hit;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] head;
  logic          push, pop, f_retire_rej, f_grant, f_done;
  logic [IW-1:0] pop_idx;

  // Round-robin scan starting just after the last allocated VM.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!scan_hit && vm_ready_for_snooper[IW'(last_s + IW'(k + 1))]
          && !busy[IW'(last_s + IW'(k + 1))]) begin
        scan_hit = 1'b1;
        scan_idx = IW'(last_s + IW'(k + 1));
      end
    end
  end

  always_comb begin
    head         = fifo_mem[rd_ptr];
    push         = (s_state == S_ACTIVE) && snooper_done;
    f_retire_rej = (f_state == F_IDLE) && (count != '0) && rej_flag[head];
    f_grant      = (f_state == F_IDLE) && (count != '0) && !rej_flag[head]
                   && vm_ready_for_forwarder[head];
    f_done       = (f_state == F_ACTIVE) && forwarder_done;
    pop          = f_retire_rej || f_done;
    pop_idx      = f_done ? fsel : head;
  end

  always_comb begin
    vm_snooper_wr_en   = '0;
    vm_snooper_done    = '0;
    vm_forwarder_rd_en = '0;
    vm_forwarder_done  = '0;
    if (s_state == S_ACTIVE) begin
      vm_snooper_wr_en[ssel] = snooper_wr_en;
      vm_snooper_done[ssel]  = snooper_done;
    end
    if (f_state == F_ACTIVE) begin
      vm_forwarder_rd_en[fsel] = forwarder_rd_en;
      vm_forwarder_done[fsel]  = forwarder_done;
    end
  end

  // Broadcasts and the read mux are forced low while reset is held.
  always_comb begin
    vm_snooper_wr_addr   = axi_aresetn ? snooper_wr_addr : '0;
    vm_snooper_wr_data   = axi_aresetn ? snooper_wr_data : '0;
    vm_forwarder_rd_addr = axi_aresetn ? forwarder_rd_addr : '0;
    forwarder_rd_data    = axi_aresetn ? vm_forwarder_rd_data[fsel*D +: D] : '0;
  end

  assign ready_for_snooper   = (s_state == S_ACTIVE);
  assign ready_for_forwarder = (f_state == F_ACTIVE);
  assign len_to_forwarder    = len_q;
  assign outstanding         = count;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      s_state <= S_IDLE;
      ssel    <= '0;
      last_s  <= IW'(N - 1);
    end else if (s_state == S_IDLE) begin
      if (scan_hit) begin
        ssel    <= scan_idx;
        last_s  <= scan_idx;
        s_state <= S_ACTIVE;
      end
    end else if (snooper_done) begin
      s_state <= S_IDLE;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      f_state <= F_IDLE;
      fsel    <= '0;
      len_q   <= '0;
    end else if (f_state == F_IDLE) begin
      if (f_grant) begin
        fsel    <= head;
        len_q   <= vm_len_to_forwarder[head*(A+1) +: (A+1)];
        f_state <= F_ACTIVE;
      end
    end else if (forwarder_done) begin
      f_state <= F_IDLE;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int unsigned i = 0; i < N; i++) fifo_mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= ssel;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Retirement wins over a same-cycle reject; a reject for the VM being
  // forwarded is ignored because that VM has already accepted its packet.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      busy     <= '0;
      rej_flag <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (pop && (pop_idx == IW'(i))) begin
          busy[i]     <= 1'b0;
          rej_flag[i] <= 1'b0;
        end else begin
          if (push && (ssel == IW'(i))) busy[i] <= 1'b1;
          if (vm_rej[i] && busy[i] && !((f_state == F_ACTIVE) && (fsel == IW'(i))))
            rej_flag[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_packetfilt_dispatcher.sv
// Directed bench for packetfilt_dispatcher: table-driven snoop allocation plus
// hand-written forward-ordering, reject, push/pop, full-queue and reset sequences.
module tb_packetfilt_dispatcher;

  localparam int N = 8;
  localparam int A = 8;
  localparam int D = 128;

  logic               axi_aclk = 1'b0;
  logic               axi_aresetn = 1'b1;
  logic [A-1:0]       snooper_wr_addr;
  logic [D-1:0]       snooper_wr_data;
  logic               snooper_wr_en;
  logic               snooper_done;
  logic               ready_for_snooper;
  logic [A-1:0]       vm_snooper_wr_addr;
  logic [D-1:0]       vm_snooper_wr_data;
  logic [N-1:0]       vm_snooper_wr_en;
  logic [N-1:0]       vm_snooper_done;
  logic [N-1:0]       vm_ready_for_snooper;
  logic [N-1:0]       vm_rej;
  logic [A-1:0]       forwarder_rd_addr;
  logic               forwarder_rd_en;
  logic [D-1:0]       forwarder_rd_data;
  logic               forwarder_done;
  logic               ready_for_forwarder;
  logic [A:0]         len_to_forwarder;
  logic [A-1:0]       vm_forwarder_rd_addr;
  logic [N-1:0]       vm_forwarder_rd_en;
  logic [N*D-1:0]     vm_forwarder_rd_data;
  logic [N-1:0]       vm_forwarder_done;
  logic [N-1:0]       vm_ready_for_forwarder;
  logic [N*(A+1)-1:0] vm_len_to_forwarder;
  logic [3:0]         outstanding;

  packetfilt_dispatcher #(.N(N), .SNOOP_FWD_ADDR_WIDTH(A), .DATA_WIDTH(D)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en), .snooper_done(snooper_done),
    .ready_for_snooper(ready_for_snooper),
    .vm_snooper_wr_addr(vm_snooper_wr_addr), .vm_snooper_wr_data(vm_snooper_wr_data),
    .vm_snooper_wr_en(vm_snooper_wr_en), .vm_snooper_done(vm_snooper_done),
    .vm_ready_for_snooper(vm_ready_for_snooper), .vm_rej(vm_rej),
    .forwarder_rd_addr(forwarder_rd_addr), .forwarder_rd_en(forwarder_rd_en),
    .forwarder_rd_data(forwarder_rd_data), .forwarder_done(forwarder_done),
    .ready_for_forwarder(ready_for_forwarder), .len_to_forwarder(len_to_forwarder),
    .vm_forwarder_rd_addr(vm_forwarder_rd_addr), .vm_forwarder_rd_en(vm_forwarder_rd_en),
    .vm_forwarder_rd_data(vm_forwarder_rd_data), .vm_forwarder_done(vm_forwarder_done),
    .vm_ready_for_forwarder(vm_ready_for_forwarder),
    .vm_len_to_forwarder(vm_len_to_forwarder),
    .outstanding(outstanding)
  );

  always #5 axi_aclk = ~axi_aclk;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [N-1:0] mask;
    int unsigned  vm;
    int unsigned  outst;
  } snoop_vec_t;

  snoop_vec_t tbl [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int unsigned i);
    logic [N-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [D-1:0] pat(input int unsigned i);
    logic [7:0] b;
    b = 8'hA0 + 8'(i);
    return {16{b}};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy_snp"}, ready_for_snooper, 0);
    check({tag, "_rdy_fwd"}, ready_for_forwarder, 0);
    check({tag, "_len"}, len_to_forwarder, 0);
    check({tag, "_outst"}, outstanding, 0);
    check({tag, "_wr_en"}, vm_snooper_wr_en, 0);
    check({tag, "_snp_done"}, vm_snooper_done, 0);
    check({tag, "_rd_en"}, vm_forwarder_rd_en, 0);
    check({tag, "_fwd_done"}, vm_forwarder_done, 0);
    check({tag, "_rd_data"}, forwarder_rd_data, 0);
    check({tag, "_wr_addr"}, vm_snooper_wr_addr, 0);
  endtask

  // Wait for allocation, write 4 words, end the packet, check queue depth.
  task automatic snoop_pkt(input logic [N-1:0] mask, input int unsigned exp_vm,
                           input int unsigned exp_out);
    int unsigned n = 0;
    vm_ready_for_snooper = mask;
    while (!ready_for_snooper && n < 20) begin
      tick();
      n++;
    end
    check("snoop_grant", ready_for_snooper, 1);
    for (int unsigned w = 0; w < 4; w++) begin
      snooper_wr_en   = 1'b1;
      snooper_wr_addr = A'(w);
      snooper_wr_data = pat(w + 16);
      #1;
      check("snoop_wr_en", vm_snooper_wr_en, oh(exp_vm));
      tick();
    end
    snooper_wr_en = 1'b0;
    snooper_done  = 1'b1;
    #1;
    check("snoop_done", vm_snooper_done, oh(exp_vm));
    tick();
    snooper_done = 1'b0;
    check("snoop_rdy_low", ready_for_snooper, 0);
    check("snoop_outst", outstanding, exp_out);
  endtask

  initial begin
    int unsigned n;

    tbl[0] = '{8'hFF, 0, 1};
    tbl[1] = '{8'hFF, 1, 2};
    tbl[2] = '{8'hFF, 2, 3};
    tbl[3] = '{8'h20, 5, 4};

    for (int unsigned i = 0; i < N; i++) begin
      vm_forwarder_rd_data[i*D +: D] = pat(i);
      vm_len_to_forwarder[i*(A+1) +: (A+1)] = 9'(i + 1);
    end
    vm_len_to_forwarder[0*(A+1) +: (A+1)] = 9'd60;
    vm_len_to_forwarder[1*(A+1) +: (A+1)] = 9'd33;
    vm_len_to_forwarder[2*(A+1) +: (A+1)] = 9'd17;
    vm_len_to_forwarder[5*(A+1) +: (A+1)] = 9'd99;

    snooper_wr_addr        = 8'h3C;
    snooper_wr_data        = pat(7);
    snooper_wr_en          = 1'b1;
    snooper_done           = 1'b1;
    forwarder_rd_addr      = 8'h55;
    forwarder_rd_en        = 1'b1;
    forwarder_done         = 1'b1;
    vm_ready_for_snooper   = '1;
    vm_ready_for_forwarder = '1;
    vm_rej                 = '0;

    #1 axi_aresetn = 1'b0;
    #1;
    check_reset_outputs("rst0");
    tick();
    tick();
    snooper_wr_en          = 1'b0;
    snooper_done           = 1'b0;
    forwarder_rd_en        = 1'b0;
    forwarder_done         = 1'b0;
    vm_ready_for_forwarder = '0;
    axi_aresetn            = 1'b1;

    for (int unsigned t = 0; t < 4; t++)
      snoop_pkt(tbl[t].mask, tbl[t].vm, tbl[t].outst);

    // No VM free: writes are dropped.
    vm_ready_for_snooper = '0;
    tick();
    snooper_wr_en = 1'b1;
    #1;
    check("idle_drop_wr", vm_snooper_wr_en, 0);
    check("idle_rdy", ready_for_snooper, 0);
    tick();
    snooper_wr_en = 1'b0;

    // VM1 ready long before VM0: VM0 still goes first.
    vm_ready_for_forwarder = 8'h02;
    for (int unsigned c = 0; c < 20; c++) tick();
    check("order_wait_rdy", ready_for_forwarder, 0);
    vm_ready_for_forwarder = 8'b0010_0111;
    tick();
    check("vm0_grant", ready_for_forwarder, 1);
    check("vm0_len", len_to_forwarder, 60);
    forwarder_rd_en   = 1'b1;
    forwarder_rd_addr = 8'h05;
    vm_rej            = 8'h02;
    #1;
    check("vm0_rd_en", vm_forwarder_rd_en, 8'h01);
    check("vm0_rd_data", forwarder_rd_data, pat(0));
    check("vm0_rd_addr", vm_forwarder_rd_addr, 8'h05);
    tick();
    vm_rej          = '0;
    forwarder_rd_en = 1'b0;
    forwarder_done  = 1'b1;
    #1;
    check("vm0_fwd_done", vm_forwarder_done, 8'h01);
    tick();
    forwarder_done = 1'b0;
    check("post_done_rdy", ready_for_forwarder, 0);
    check("post_done_outst", outstanding, 3);
    tick();
    check("rej_pop_rdy", ready_for_forwarder, 0);
    check("rej_pop_outst", outstanding, 2);
    tick();
    check("vm2_grant", ready_for_forwarder, 1);
    check("vm2_len", len_to_forwarder, 17);
    check("vm2_rd_data", forwarder_rd_data, pat(2));

    // Simultaneous push and pop at outstanding=3.
    snoop_pkt(8'h03, 0, 3);
    n = 0;
    while (!ready_for_snooper && n < 20) begin
      tick();
      n++;
    end
    check("pp_snoop_grant", ready_for_snooper, 1);
    snooper_wr_en = 1'b1;
    #1;
    check("pp_wr_en_vm1", vm_snooper_wr_en, 8'h02);
    snooper_wr_en  = 1'b0;
    snooper_done   = 1'b1;
    forwarder_done = 1'b1;
    #1;
    check("pp_snp_done", vm_snooper_done, 8'h02);
    check("pp_fwd_done", vm_forwarder_done, 8'h04);
    tick();
    snooper_done   = 1'b0;
    forwarder_done = 1'b0;
    check("pp_outst", outstanding, 3);
    check("pp_rdy_fwd", ready_for_forwarder, 0);
    tick();
    check("vm5_grant", ready_for_forwarder, 1);
    check("vm5_len", len_to_forwarder, 99);
    check("vm5_rd_data", forwarder_rd_data, pat(5));

    // Reset mid-snoop (VM2) and mid-forward (VM5).
    vm_ready_for_snooper = '1;
    n = 0;
    while (!ready_for_snooper && n < 20) begin
      tick();
      n++;
    end
    snooper_wr_en   = 1'b1;
    forwarder_rd_en = 1'b1;
    #1;
    check("mid_wr_en_vm2", vm_snooper_wr_en, 8'h04);
    check("mid_rd_en_vm5", vm_forwarder_rd_en, 8'h20);
    axi_aresetn    = 1'b0;
    snooper_done   = 1'b1;
    forwarder_done = 1'b1;
    #1;
    check_reset_outputs("rst1");
    tick();
    tick();
    snooper_wr_en          = 1'b0;
    snooper_done           = 1'b0;
    forwarder_rd_en        = 1'b0;
    forwarder_done         = 1'b0;
    vm_ready_for_forwarder = '0;
    axi_aresetn            = 1'b1;

    // Fill every VM; first allocation after reset must be VM0.
    for (int unsigned i = 0; i < N; i++) snoop_pkt(8'hFF, i, i + 1);
    for (int unsigned c = 0; c < 5; c++) tick();
    check("full_rdy_snp", ready_for_snooper, 0);
    check("full_outst", outstanding, 8);
    snooper_wr_en = 1'b1;
    #1;
    check("full_drop_wr", vm_snooper_wr_en, 0);
    tick();
    snooper_wr_en = 1'b0;

    // Retire VM0 by reject; the snooper re-opens on VM0 (after last_s=7).
    vm_rej = 8'h01;
    tick();
    vm_rej = '0;
    check("full_rej_outst", outstanding, 8);
    tick();
    check("full_pop_outst", outstanding, 7);
    check("full_pop_rdy_fwd", ready_for_forwarder, 0);
    snoop_pkt(8'hFF, 0, 8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
